ascon_serial_sequencer: RTL and testbench

- Parallel-to-serial controller that drives the bit-serial Ascon core on the user-project side.
- Accepts one parallel request: key, nonce, associated data, input data and encrypt/decrypt select. Resets the core, shifts all operands in, pulses start, waits for ready, then shifts ciphertext/plaintext and tag back out.
- Returns the result through a valid/ready response handshake.
- Replaces testbench-driven GPIO sequencing, so firmware or a bus slave can issue one-shot AEAD jobs.

---
 rtl/ascon_seq_pkg.sv | 31 +++
 rtl/ascon_seq_shifter.sv | 31 +++
 rtl/ascon_serial_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_ascon_serial_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_seq_pkg.sv
// Shared types and default geometry for the serial Ascon sequencer.
package ascon_seq_pkg;

  localparam int K_DEF        = 128;
  localparam int Y_DEF        = 104;
  localparam int L_DEF        = 40;
  localparam int NT_W         = 128;
  localparam int MAX_DEF      = 128;
  localparam int CRST_DEF     = 2;
  localparam int START_DEF    = 3;
  localparam int RDELAY_DEF   = 2;
  localparam int TIMEOUT_DEF  = 4096;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    LOAD,
    START,
    WAIT,
    GAP,
    READ,
    RESP
  } seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ascon_seq_shifter.sv
// Parallel-load, MSB-first shift register; zeros enter at the LSB so the
// serial output reads 0 once the operand has been fully shifted out.
module ascon_seq_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  output logic         bit_out
);

  logic [W-1:0] sreg;

  // Operand register: load takes priority over shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_data;
    end else if (shift) begin
      sreg <= {sreg[W-2:0], 1'b0};
    end else begin
      sreg <= sreg;
    end
  end

  assign bit_out = sreg[W-1];

endmodule

// File: rtl/ascon_serial_sequencer.sv
// One-shot AEAD job controller: resets the bit-serial Ascon core, streams
// operands in, starts it, waits for ready, and collects data/tag serially.
module ascon_serial_sequencer
  import ascon_seq_pkg::*;
#(
  parameter int K            = K_DEF,
  parameter int Y            = Y_DEF,
  parameter int L            = L_DEF,
  parameter int CRST_CYCLES  = CRST_DEF,
  parameter int START_CYCLES = START_DEF,
  parameter int READ_DELAY   = RDELAY_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_decrypt,
  input  logic [K-1:0]   req_key,
  input  logic [127:0]   req_nonce,
  input  logic [L-1:0]   req_ad,
  input  logic [Y-1:0]   req_data,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [Y-1:0]   rsp_data,
  output logic [127:0]   rsp_tag,
  output logic           rsp_timeout,
  output logic           busy,
  output logic           core_rst,
  output logic           core_key_si,
  output logic           core_nonce_si,
  output logic           core_ad_si,
  output logic           core_data_si,
  output logic           core_start_si,
  output logic           core_decrypt,
  input  logic           core_data_so,
  input  logic           core_tag_so,
  input  logic           core_ready_so
);

  localparam int MAX   = max3(K, Y, L);
  localparam int CTR_W = $clog2((MAX > TIMEOUT) ? MAX : TIMEOUT);
  localparam int IDX_W = $clog2(MAX);

  seq_state_e       state, state_next;
  logic [CTR_W-1:0] ctr, ctr_next;
  logic             accept;
  logic             shift_en;
  logic             set_timeout;
  logic             load_active;
  logic             key_bit, nonce_bit, ad_bit, data_bit;
  logic [IDX_W-1:0] idx;

  assign accept   = (state == IDLE) && req_valid;
  assign shift_en = (state == LOAD);
  assign idx      = ctr[IDX_W-1:0];

  // Next-state and phase counter; every phase leaves on its terminal count.
  always_comb begin
    state_next  = state;
    ctr_next    = ctr;
    set_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = CRST;
          ctr_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      CRST: begin
        if (ctr == CTR_W'(CRST_CYCLES - 1)) begin
          state_next = LOAD;
          ctr_next   = '0;
        end else begin
          ctr_next = ctr + CTR_W'(1);
        end
      end
      LOAD: begin
        if (ctr == CTR_W'(MAX - 1)) begin
          state_next = START;
          ctr_next   = '0;
        end else begin
          ctr_next = ctr + CTR_W'(1);
        end
      end
      START: begin
        if (ctr == CTR_W'(START_CYCLES - 1)) begin
          state_next = WAIT;
          ctr_next   = '0;
        end else begin
          ctr_next = ctr + CTR_W'(1);
        end
      end
      WAIT: begin
        if (core_ready_so) begin
          state_next = GAP;
          ctr_next   = '0;
        end else if (ctr == CTR_W'(TIMEOUT - 1)) begin
          state_next  = RESP;
          ctr_next    = '0;
          set_timeout = 1'b1;
        end else begin
          ctr_next = ctr + CTR_W'(1);
        end
      end
      GAP: begin
        if (ctr == CTR_W'(READ_DELAY - 1)) begin
          state_next = READ;
          ctr_next   = '0;
        end else begin
          ctr_next = ctr + CTR_W'(1);
        end
      end
      READ: begin
        if (ctr == CTR_W'(MAX - 1)) begin
          state_next = RESP;
          ctr_next   = '0;
        end else begin
          ctr_next = ctr + CTR_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
        ctr_next   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ctr   <= '0;
    end else begin
      state <= state_next;
      ctr   <= ctr_next;
    end
  end

  // Control outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      rsp_valid     <= 1'b0;
      core_rst      <= 1'b0;
      core_start_si <= 1'b0;
      load_active   <= 1'b0;
    end else begin
      req_ready     <= (state_next == IDLE);
      busy          <= (state_next != IDLE);
      rsp_valid     <= (state_next == RESP);
      core_rst      <= (state_next == CRST);
      core_start_si <= (state_next == START);
      load_active   <= (state_next == LOAD);
    end
  end

  // Response capture; results persist through RESP and clear on the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data     <= '0;
      rsp_tag      <= '0;
      rsp_timeout  <= 1'b0;
      core_decrypt <= 1'b0;
    end else if (accept) begin
      rsp_data     <= '0;
      rsp_tag      <= '0;
      rsp_timeout  <= 1'b0;
      core_decrypt <= req_decrypt;
    end else if (state == READ) begin
      if (ctr < CTR_W'(Y)) begin
        rsp_data[idx] <= core_data_so;
      end else begin
        rsp_data <= rsp_data;
      end
      rsp_tag[idx] <= core_tag_so;
    end else if (set_timeout) begin
      rsp_timeout <= 1'b1;
    end else begin
      rsp_timeout <= rsp_timeout;
    end
  end

  ascon_seq_shifter #(.W(K)) u_key (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_data(req_key),
    .shift(shift_en), .bit_out(key_bit)
  );

  ascon_seq_shifter #(.W(128)) u_nonce (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_data(req_nonce),
    .shift(shift_en), .bit_out(nonce_bit)
  );

  ascon_seq_shifter #(.W(L)) u_ad (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_data(req_ad),
    .shift(shift_en), .bit_out(ad_bit)
  );

  ascon_seq_shifter #(.W(Y)) u_data (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_data(req_data),
    .shift(shift_en), .bit_out(data_bit)
  );

  // Serial pins are forced low outside LOAD so START and idle hold them at 0.
  assign core_key_si   = load_active & key_bit;
  assign core_nonce_si = load_active & nonce_bit;
  assign core_ad_si    = load_active & ad_bit;
  assign core_data_si  = load_active & data_bit;

endmodule

// File: tb/tb_ascon_serial_sequencer.sv
// Directed bench for ascon_serial_sequencer with a behavioural stand-in for
// the serial core (fixed keystream, XOR-folded tag).
module tb_ascon_serial_sequencer;

  localparam logic [127:0] KEY   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
  localparam logic [127:0] NONCE = 128'h05885e606e1271b8d47a74c7b297a318;
  localparam logic [39:0]  AD    = 40'h4153434f4e;
  localparam logic [103:0] PT    = 104'h6173636f6e2d756e6963617373;
  localparam logic [103:0] CT    = 104'h18490112f8d5867a830748390b;
  localparam logic [103:0] KS    = PT ^ CT;
  localparam logic [127:0] TAG   = KEY ^ NONCE ^ {AD, 88'h0} ^ {PT, 24'h0};
  localparam int LAT      = 10;
  localparam int LAT_OK   = 2 + 128 + 3 + (LAT + 1) + 2 + 128;
  localparam int LAT_TO   = 2 + 128 + 3 + 4096;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_decrypt;
  logic [127:0] req_key, req_nonce;
  logic [39:0]  req_ad;
  logic [103:0] req_data;
  logic         rsp_valid, rsp_ready;
  logic [103:0] rsp_data;
  logic [127:0] rsp_tag;
  logic         rsp_timeout, busy;
  logic         core_rst, core_key_si, core_nonce_si, core_ad_si, core_data_si;
  logic         core_start_si, core_decrypt;
  logic         core_data_so, core_tag_so, core_ready_so;

  int checks = 0;
  int failures = 0;

  ascon_serial_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_decrypt(req_decrypt),
    .req_key(req_key), .req_nonce(req_nonce), .req_ad(req_ad), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout), .busy(busy),
    .core_rst(core_rst), .core_key_si(core_key_si), .core_nonce_si(core_nonce_si),
    .core_ad_si(core_ad_si), .core_data_si(core_data_si),
    .core_start_si(core_start_si), .core_decrypt(core_decrypt),
    .core_data_so(core_data_so), .core_tag_so(core_tag_so),
    .core_ready_so(core_ready_so)
  );

  always #5 clk = ~clk;

  // Core stand-in: absorbs 128 bits after reset, raises ready LAT cycles after
  // start, then presents sample i on the cycle the sequencer reads it.
  logic [127:0] cap_key = '0, cap_nonce = '0, cap_ad = '0, cap_data = '0;
  int           ld_cnt = 0, lat_cnt = 0, rcnt = 0;
  logic         start_seen = 1'b0, rdy = 1'b0, core_dead = 1'b0;
  logic [103:0] stub_out, stub_plain;
  logic [127:0] stub_tag;
  logic [6:0]   sel;

  always @(posedge clk) begin
    if (core_rst) begin
      cap_key <= '0; cap_nonce <= '0; cap_ad <= '0; cap_data <= '0;
      ld_cnt <= 0; lat_cnt <= 0; rcnt <= 0; start_seen <= 1'b0; rdy <= 1'b0;
    end else begin
      if (ld_cnt < 128) begin
        cap_key   <= {cap_key[126:0], core_key_si};
        cap_nonce <= {cap_nonce[126:0], core_nonce_si};
        cap_ad    <= {cap_ad[126:0], core_ad_si};
        cap_data  <= {cap_data[126:0], core_data_si};
        ld_cnt    <= ld_cnt + 1;
      end
      if (core_start_si) start_seen <= 1'b1;
      else if (start_seen && !rdy && !core_dead) begin
        if (lat_cnt == LAT - 1) begin
          rdy  <= 1'b1;
          rcnt <= 0;
        end
        lat_cnt <= lat_cnt + 1;
      end
      if (rdy) rcnt <= rcnt + 1;
    end
  end

  assign stub_out      = cap_data[127:24] ^ KS;
  assign stub_plain    = core_decrypt ? stub_out : cap_data[127:24];
  assign stub_tag      = cap_key ^ cap_nonce ^ cap_ad ^ {stub_plain, 24'h0};
  assign core_ready_so = rdy;

  always_comb begin
    sel          = 7'((rcnt - 3) & 127);
    core_data_so = 1'b0;
    core_tag_so  = 1'b0;
    if (rdy && rcnt >= 3 && rcnt < 3 + 128) begin
      core_tag_so = stub_tag[sel];
      if (rcnt < 3 + 104) core_data_so = stub_out[sel];
    end
  end

  // Pin monitor: pulse widths and the bit streams seen during load.
  int           rst_hi = 0, start_hi = 0, lidx = 128;
  logic [127:0] mon_key = '0, mon_nonce = '0, mon_ad = '0, mon_data = '0;
  logic         mon_first_key = 1'b1;

  always @(negedge clk) begin
    if (core_rst) begin
      rst_hi <= rst_hi + 1;
      lidx   <= 0;
    end else if (lidx < 128) begin
      mon_key[7'(127 - lidx)]   <= core_key_si;
      mon_nonce[7'(127 - lidx)] <= core_nonce_si;
      mon_ad[7'(127 - lidx)]    <= core_ad_si;
      mon_data[7'(127 - lidx)]  <= core_data_si;
      if (lidx == 0) mon_first_key <= core_key_si;
      lidx <= lidx + 1;
    end
    if (core_start_si) start_hi <= start_hi + 1;
  end

  task automatic issue(input logic dec, input logic [103:0] data);
    @(negedge clk);
    req_valid = 1'b1; req_decrypt = dec; req_key = KEY; req_nonce = NONCE;
    req_ad = AD; req_data = data;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output logic got);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6000 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        lat = i;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rsp_wait: rsp_valid=%0b after 6000 cycles, required 1", rsp_valid);
    end
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 104'h0 || rsp_tag !== 128'h0) begin failures++; $display("FAIL reset_rsp_regs data=%h tag=%h exp=0", rsp_data, rsp_tag); end
    checks++; if ({core_rst, core_start_si, core_decrypt, core_key_si, rsp_timeout} !== 5'b0) begin
      failures++; $display("FAIL reset_core_pins got=%b exp=00000", {core_rst, core_start_si, core_decrypt, core_key_si, rsp_timeout}); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL idle_rsp_ready busy=%b rsp_valid=%b exp=0/0", busy, rsp_valid); end
  endtask

  task automatic test_encrypt_and_load();
    int lat; logic got; int rst_base, start_base;
    rst_base = rst_hi; start_base = start_hi;
    issue(1'b0, PT);
    wait_rsp(lat, got);
    checks++; if (rsp_data !== CT) begin failures++; $display("FAIL enc_data got=%h exp=%h", rsp_data, CT); end
    checks++; if (rsp_tag !== TAG) begin failures++; $display("FAIL enc_tag got=%h exp=%h", rsp_tag, TAG); end
    checks++; if (rsp_timeout !== 1'b0 || core_decrypt !== 1'b0) begin failures++; $display("FAIL enc_flags timeout=%b decrypt=%b exp=0/0", rsp_timeout, core_decrypt); end
    checks++; if (lat != LAT_OK) begin failures++; $display("FAIL enc_latency got=%0d exp=%0d", lat, LAT_OK); end
    checks++; if (rst_hi - rst_base != 2) begin failures++; $display("FAIL load_core_rst_width got=%0d exp=2", rst_hi - rst_base); end
    checks++; if (start_hi - start_base != 3) begin failures++; $display("FAIL load_start_width got=%0d exp=3", start_hi - start_base); end
    checks++; if (mon_first_key !== 1'b0) begin failures++; $display("FAIL load_first_key got=%b exp=0", mon_first_key); end
    checks++; if (mon_ad !== {AD, 88'h0}) begin failures++; $display("FAIL load_ad_stream got=%h exp=%h", mon_ad, {AD, 88'h0}); end
    checks++; if (mon_key !== KEY || mon_nonce !== NONCE) begin failures++; $display("FAIL load_key_nonce key=%h nonce=%h", mon_key, mon_nonce); end
    checks++; if (mon_data !== {PT, 24'h0}) begin failures++; $display("FAIL load_data_stream got=%h exp=%h", mon_data, {PT, 24'h0}); end
    finish_rsp();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL enc_release rsp_valid=%b req_ready=%b exp=0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_decrypt();
    int lat; logic got;
    issue(1'b1, CT);
    wait_rsp(lat, got);
    checks++; if (rsp_data !== PT) begin failures++; $display("FAIL dec_data got=%h exp=%h", rsp_data, PT); end
    checks++; if (rsp_tag !== TAG) begin failures++; $display("FAIL dec_tag got=%h exp=%h", rsp_tag, TAG); end
    checks++; if (core_decrypt !== 1'b1) begin failures++; $display("FAIL dec_mode got=%b exp=1", core_decrypt); end
    finish_rsp();
  endtask

  task automatic test_timeout();
    int lat; logic got;
    core_dead = 1'b1;
    issue(1'b0, PT);
    wait_rsp(lat, got);
    checks++; if (lat != LAT_TO) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", lat, LAT_TO); end
    checks++; if (rsp_timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", rsp_timeout); end
    checks++; if (rsp_data !== 104'h0 || rsp_tag !== 128'h0) begin failures++; $display("FAIL to_regs data=%h tag=%h exp=0", rsp_data, rsp_tag); end
    finish_rsp();
    core_dead = 1'b0;
  endtask

  task automatic test_back_to_back_backpressure();
    int lat; logic got; int bad;
    logic [103:0] d0; logic [127:0] t0;
    issue(1'b0, PT);
    wait_rsp(lat, got);
    checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL bp_timeout_cleared got=%b exp=0", rsp_timeout); end
    d0 = rsp_data; t0 = rsp_tag; bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      req_valid   = (i >= 10 && i < 14);
      req_decrypt = 1'b1; req_data = CT ^ 104'h1;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1 || rsp_data !== d0 || rsp_tag !== t0)
        bad++;
    end
    req_valid = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_stable unstable_cycles=%0d exp=0", bad); end
    checks++; if (rsp_data !== CT || rsp_tag !== TAG) begin failures++; $display("FAIL bp_intact data=%h tag=%h exp=%h/%h", rsp_data, rsp_tag, CT, TAG); end
    finish_rsp();
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_dropped busy=%b req_ready=%b exp=0/1", busy, req_ready); end
  endtask

  task automatic test_reset_midload();
    int lat; logic got;
    issue(1'b1, PT);
    repeat (62) @(negedge clk);
    checks++; if (busy !== 1'b1 || core_rst !== 1'b0) begin failures++; $display("FAIL mid_in_load busy=%b core_rst=%b exp=1/0", busy, core_rst); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL mid_reset_ctrl busy=%b req_ready=%b rsp_valid=%b exp=0/1/0", busy, req_ready, rsp_valid); end
    checks++; if ({core_rst, core_key_si, core_nonce_si, core_ad_si, core_data_si, core_start_si, core_decrypt} !== 7'b0) begin
      failures++; $display("FAIL mid_reset_core got=%b exp=0000000",
        {core_rst, core_key_si, core_nonce_si, core_ad_si, core_data_si, core_start_si, core_decrypt}); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, PT);
    wait_rsp(lat, got);
    checks++; if (rsp_data !== CT || rsp_tag !== TAG) begin failures++; $display("FAIL mid_next_job data=%h tag=%h exp=%h/%h", rsp_data, rsp_tag, CT, TAG); end
    finish_rsp();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_decrypt = 1'b0; req_key = '0;
    req_nonce = '0; req_ad = '0; req_data = '0; rsp_ready = 1'b0;
    test_reset();
    test_encrypt_and_load();
    test_decrypt();
    test_timeout();
    test_back_to_back_backpressure();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
